// File: rtl/mem_arb_pkg.sv
// Shared encodings for the VRAM port arbiter: per-slot owner tag and counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_CPU_WR = 2'd2,
    OWN_VGA_RD = 2'd3
  } owner_e;

  function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester and RAM signal bundle; slave is the arbiter view, master the CPU/VGA/RAM view.
interface vram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_port_arbiter_prio_starve_arb.sv
// Fixed-priority VGA-over-CPU arbiter with a saturating starvation counter that forces a CPU slot.
module prio_starve_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic vga_req,
  output logic cpu_gnt,
  output logic vga_gnt
);

  localparam int unsigned CNT_W = starve_cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             at_limit;

  always_comb begin
    at_limit   = (starve_cnt == CNT_MAX);
    cpu_gnt    = 1'b0;
    vga_gnt    = 1'b0;
    starve_nxt = starve_cnt;

    if (rst) begin
      if (vga_req && !(cpu_req && at_limit)) begin
        vga_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end

    // Counts only contended VGA wins; an idle CPU never accumulates credit.
    if (!cpu_req || cpu_gnt) begin
      starve_nxt = '0;
    end else if (vga_gnt && !at_limit) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one single-port RAM between CPU and VGA; registers the winning command and tags read returns.
module vram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  vram_port_arbiter_if.slave bus
);

  logic              cpu_gnt;
  logic              vga_gnt;

  owner_e            owner_q;
  owner_e            owner_d;
  owner_e            ret_q;

  logic              mem_en_q;
  logic              mem_en_d;
  logic              mem_we_q;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] mem_wdata_d;

  prio_starve_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .cpu_req(bus.cpu_req),
    .vga_req(bus.vga_req),
    .cpu_gnt(cpu_gnt),
    .vga_gnt(vga_gnt)
  );

  always_comb begin
    owner_d     = OWN_NONE;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (vga_gnt) begin
      owner_d    = OWN_VGA_RD;
      mem_en_d   = 1'b1;
      mem_addr_d = bus.vga_addr;
    end else if (cpu_gnt) begin
      owner_d     = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.cpu_we;
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
    end
  end

  // owner_q rides with the issued command; ret_q lines up with the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      ret_q       <= OWN_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      ret_q       <= owner_q;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_rvalid = (ret_q == OWN_CPU_RD);
  assign bus.vga_rvalid = (ret_q == OWN_VGA_RD);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.vga_rdata  = bus.mem_rdata;

  gnt_onehot: assert property (@(posedge clk) !(cpu_gnt && vga_gnt));

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed, table-driven bench for vram_port_arbiter with a behavioural RAM on the mem port.
module tb_vram_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
  vram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  vram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  vram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // RAM model: fixed background contents plus one overridable written word.
  logic        wr_seen = 1'b0;
  logic [15:0] wr_addr = 16'h0;
  logic [15:0] wr_data = 16'h0;

  function automatic logic [15:0] ram_base(input logic [15:0] a);
    if (a == 16'h0004) return 16'h0002;
    if (a == 16'h0200) return 16'h5A5A;
    if (a >= 16'h0100 && a <= 16'h0103) return 16'h00A0 + (a - 16'h0100);
    return ~a;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      wr_seen <= 1'b1;
      wr_addr <= bus.mem_addr;
      wr_data <= bus.mem_wdata;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= (wr_seen && bus.mem_addr == wr_addr) ? wr_data : ram_base(bus.mem_addr);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        vr;
    logic [15:0] va;
    logic        e_cg;
    logic        e_vg;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic        e_crv;
    logic        e_vrv;
    logic [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
    input logic vr, input logic [15:0] va,
    input logic e_cg, input logic e_vg, input logic e_en, input logic e_we,
    input logic [15:0] e_addr, input logic [15:0] e_wd,
    input logic e_crv, input logic e_vrv, input logic [15:0] e_rd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.vr = vr; v.va = va;
    v.e_cg = e_cg; v.e_vg = e_vg; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_crv = e_crv; v.e_vrv = e_vrv; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t vecs [29];

  initial begin
    //                 cr cw ca       cd       vr va        cg vg en we addr     wd       crv vrv rd
    vecs[0]  = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0200, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000);
    vecs[2]  = mk(1, 0, 16'h0004, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5A5A);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0000);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002);
    vecs[5]  = mk(1, 1, 16'h0004, 16'h0007, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 16'h0004, 16'h0007, 0, 0, 16'h0000);
    vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[8]  = mk(1, 0, 16'h0004, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0000);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0101, 0, 1, 1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0007);
    vecs[11] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0102, 0, 1, 1, 0, 16'h0101, 16'h0000, 0, 1, 16'h00A0);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0103, 0, 1, 1, 0, 16'h0102, 16'h0000, 0, 1, 16'h00A1);
    vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0103, 16'h0000, 0, 1, 16'h00A2);
    vecs[14] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A3);
    vecs[15] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[16] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[17] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000);
    vecs[18] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[19] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[20] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 1, 0, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[21] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0004, 16'h0000, 0, 1, 16'h00A0);
    vecs[22] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0007);
    vecs[23] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[24] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 0, 1, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[25] = mk(1, 0, 16'h0004, 16'h0000, 1, 16'h0100, 1, 0, 1, 0, 16'h0100, 16'h0000, 0, 1, 16'h00A0);
    vecs[26] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0004, 16'h0000, 0, 1, 16'h00A0);
    vecs[27] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0007);
    vecs[28] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);

    rst           = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0004;
    bus.cpu_wdata = 16'h0000;
    bus.vga_req   = 1'b1;
    bus.vga_addr  = 16'h0200;
    bus1.cpu_req   = 1'b0;
    bus1.cpu_we    = 1'b0;
    bus1.cpu_addr  = 16'h0000;
    bus1.cpu_wdata = 16'h0000;
    bus1.vga_req   = 1'b0;
    bus1.vga_addr  = 16'h0000;
    bus1.mem_rdata = 16'h0000;

    // Reset held with both requesters active.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d cpu_gnt", c), {31'd0, bus.cpu_gnt}, 32'd0);
      chk($sformatf("rst%0d vga_gnt", c), {31'd0, bus.vga_gnt}, 32'd0);
      chk($sformatf("rst%0d mem_en", c), {31'd0, bus.mem_en}, 32'd0);
      chk($sformatf("rst%0d mem_we", c), {31'd0, bus.mem_we}, 32'd0);
      chk($sformatf("rst%0d mem_addr", c), {16'd0, bus.mem_addr}, 32'd0);
      chk($sformatf("rst%0d mem_wdata", c), {16'd0, bus.mem_wdata}, 32'd0);
      chk($sformatf("rst%0d cpu_rvalid", c), {31'd0, bus.cpu_rvalid}, 32'd0);
      chk($sformatf("rst%0d vga_rvalid", c), {31'd0, bus.vga_rvalid}, 32'd0);
    end

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      bus.cpu_req   = vecs[i].cr;
      bus.cpu_we    = vecs[i].cw;
      bus.cpu_addr  = vecs[i].ca;
      bus.cpu_wdata = vecs[i].cd;
      bus.vga_req   = vecs[i].vr;
      bus.vga_addr  = vecs[i].va;
      #1;
      chk($sformatf("v%0d cpu_gnt", i), {31'd0, bus.cpu_gnt}, {31'd0, vecs[i].e_cg});
      chk($sformatf("v%0d vga_gnt", i), {31'd0, bus.vga_gnt}, {31'd0, vecs[i].e_vg});
      chk($sformatf("v%0d mem_en", i), {31'd0, bus.mem_en}, {31'd0, vecs[i].e_en});
      chk($sformatf("v%0d cpu_rvalid", i), {31'd0, bus.cpu_rvalid}, {31'd0, vecs[i].e_crv});
      chk($sformatf("v%0d vga_rvalid", i), {31'd0, bus.vga_rvalid}, {31'd0, vecs[i].e_vrv});
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d mem_we", i), {31'd0, bus.mem_we}, {31'd0, vecs[i].e_we});
        chk($sformatf("v%0d mem_addr", i), {16'd0, bus.mem_addr}, {16'd0, vecs[i].e_addr});
        if (vecs[i].e_we)
          chk($sformatf("v%0d mem_wdata", i), {16'd0, bus.mem_wdata}, {16'd0, vecs[i].e_wd});
      end
      if (vecs[i].e_crv)
        chk($sformatf("v%0d cpu_rdata", i), {16'd0, bus.cpu_rdata}, {16'd0, vecs[i].e_rd});
      if (vecs[i].e_vrv)
        chk($sformatf("v%0d vga_rdata", i), {16'd0, bus.vga_rdata}, {16'd0, vecs[i].e_rd});
    end

    // Reset arriving the cycle after a CPU read grant drops the read.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0004;
    bus.vga_req  = 1'b0;
    #1;
    chk("midrst cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    @(negedge clk);
    rst         = 1'b0;
    bus.vga_req = 1'b1;
    #1;
    chk("midrst gnt_forced cpu", {31'd0, bus.cpu_gnt}, 32'd0);
    chk("midrst gnt_forced vga", {31'd0, bus.vga_gnt}, 32'd0);
    @(negedge clk);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    bus.vga_req = 1'b0;
    #1;
    chk("midrst starve_cnt", 32'(dut.u_arb.starve_cnt), 32'd0);
    chk("midrst mem_en", {31'd0, bus.mem_en}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midrst%0d cpu_rvalid", c), {31'd0, bus.cpu_rvalid}, 32'd0);
      chk($sformatf("midrst%0d vga_rvalid", c), {31'd0, bus.vga_rvalid}, 32'd0);
      @(negedge clk);
      #1;
    end

    // STARVE_MAX=1 instance: continuous contention alternates V,C,V,C,...
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus1.cpu_req = 1'b1;
      bus1.vga_req = 1'b1;
      #1;
      chk($sformatf("alt%0d vga_gnt", c), {31'd0, bus1.vga_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d cpu_gnt", c), {31'd0, bus1.cpu_gnt}, (c % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    bus1.cpu_req = 1'b0;
    bus1.vga_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
